pipelined_adder_tree: RTL and testbench

PIPELINED_ADDER_TREE -- requirements
Module: pipelined_adder_tree

---
 rtl/pipelined_adder_tree.sv | 78 +++++++
 tb/tb_pipelined_adder_tree.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/pipelined_adder_tree.sv
// Pipelined balanced binary adder tree.
// Sums INPUTS operands of WIDTH bits at full precision over LEVELS register
// stages. A single advance signal (downstream ready or final stage empty)
// moves the whole pipeline, so bubbles travel with the data.
// Partial sums grow by one bit per level, which keeps every sum exact.
module pipelined_adder_tree #(
    parameter int WIDTH  = 8,
    parameter int INPUTS = 4,
    parameter int SIGNED = 0
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [INPUTS*WIDTH-1:0]               in_data,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    output logic [WIDTH+$clog2(INPUTS)-1:0]       out_sum,
    output logic                                  out_valid,
    input  logic                                  out_ready
);

    localparam int LEVELS    = $clog2(INPUTS);
    localparam int SUM_WIDTH = WIDTH + LEVELS;

    logic w_advance;

    for (genvar gl = 0; gl < LEVELS; gl++) begin : g_lvl
        localparam int IW = WIDTH + gl;
        localparam int OW = IW + 1;
        localparam int N  = INPUTS >> (gl + 1);

        logic [2*N*IW-1:0] w_src;
        logic              w_src_vld;
        logic [N*OW-1:0]   w_sum;
        logic [OW-1:0]     w_a;
        logic [OW-1:0]     w_b;
        logic [N*OW-1:0]   r_sum;
        logic              r_vld;

        if (gl == 0) begin : g_first
            assign w_src     = in_data;
            assign w_src_vld = in_valid;
        end else begin : g_next
            assign w_src     = g_lvl[gl-1].r_sum;
            assign w_src_vld = g_lvl[gl-1].r_vld;
        end

        // Pairwise adds, each operand extended by one bit (sign or zero) first
        always_comb begin
            w_sum = '0;
            w_a   = '0;
            w_b   = '0;
            for (int k = 0; k < N; k++) begin
                w_a = {(SIGNED != 0) & w_src[2*k*IW + IW - 1], w_src[2*k*IW +: IW]};
                w_b = {(SIGNED != 0) & w_src[(2*k+1)*IW + IW - 1], w_src[(2*k+1)*IW +: IW]};
                w_sum[k*OW +: OW] = w_a + w_b;
            end
        end

        // Stage register: valid always follows on advance, data only for valid sets
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_vld <= 1'b0;
                r_sum <= '0;
            end else if (w_advance) begin
                r_vld <= w_src_vld;
                if (w_src_vld) begin
                    r_sum <= w_sum;
                end
            end
        end
    end

    assign out_sum   = g_lvl[LEVELS-1].r_sum[SUM_WIDTH-1:0];
    assign out_valid = g_lvl[LEVELS-1].r_vld;
    assign w_advance = out_ready | ~out_valid;
    assign in_ready  = w_advance;

endmodule

// File: tb/tb_pipelined_adder_tree.sv
// Directed bench: an unsigned and a signed 4x8-bit tree share all inputs,
// so every operand set is checked against both interpretations.
module tb_pipelined_adder_tree;

    logic        clk;
    logic        rst;
    logic [31:0] in_data;
    logic        in_valid;
    logic        out_ready;
    logic        u_in_ready;
    logic [9:0]  u_out_sum;
    logic        u_out_valid;
    logic        s_in_ready;
    logic [9:0]  s_out_sum;
    logic        s_out_valid;

    int total;
    int bad;

    pipelined_adder_tree #(.WIDTH(8), .INPUTS(4), .SIGNED(0)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (u_in_ready),
        .out_sum   (u_out_sum),
        .out_valid (u_out_valid),
        .out_ready (out_ready)
    );

    pipelined_adder_tree #(.WIDTH(8), .INPUTS(4), .SIGNED(1)) s_dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (s_in_ready),
        .out_sum   (s_out_sum),
        .out_valid (s_out_valid),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] pk(input int a, input int b, input int c, input int d);
        logic [7:0] ba, bb, bc, bd;
        ba = a[7:0];
        bb = b[7:0];
        bc = c[7:0];
        bd = d[7:0];
        return {bd, bc, bb, ba};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One isolated set: accepted at the next edge, visible after the edge after that
    task automatic single(input string tag, input logic [31:0] data,
                          input logic [9:0] exp_u, input logic [9:0] exp_s);
        in_data  = data;
        in_valid = 1'b1;
        chk({tag, "_in_ready"}, {31'd0, u_in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
        in_data  = 32'hDEAD_BEEF;
        chk({tag, "_lat1_valid"}, {31'd0, u_out_valid}, 32'd0);
        tick();
        chk({tag, "_u_valid"}, {31'd0, u_out_valid}, 32'd1);
        chk({tag, "_u_sum"}, {22'd0, u_out_sum}, {22'd0, exp_u});
        chk({tag, "_s_valid"}, {31'd0, s_out_valid}, 32'd1);
        chk({tag, "_s_sum"}, {22'd0, s_out_sum}, {22'd0, exp_s});
        tick();
        chk({tag, "_drained"}, {31'd0, u_out_valid}, 32'd0);
    endtask

    logic [31:0] vec   [8];
    logic [9:0]  exp_u [8];
    logic [9:0]  exp_s [8];

    initial begin
        total     = 0;
        bad       = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = 32'd0;
        out_ready = 1'b1;

        // Streaming table: {10i, i+1, 3i, 200-i}; unsigned 201+13i, signed 13i-55
        for (int i = 0; i < 8; i++) vec[i] = pk(10*i, i+1, 3*i, 200-i);
        exp_u = '{10'd201, 10'd214, 10'd227, 10'd240, 10'd253, 10'd266, 10'd279, 10'd292};
        exp_s = '{10'd969, 10'd982, 10'd995, 10'd1008, 10'd1021, 10'd10, 10'd23, 10'd36};

        #2;
        chk("rst_out_valid", {31'd0, u_out_valid}, 32'd0);
        chk("rst_out_sum", {22'd0, u_out_sum}, 32'd0);
        chk("rst_in_ready", {31'd0, u_in_ready}, 32'd1);
        chk("rst_s_out_valid", {31'd0, s_out_valid}, 32'd0);
        tick();
        chk("rst_hold_valid", {31'd0, u_out_valid}, 32'd0);
        rst = 1'b0;

        single("basic", pk(4, 5, 11, 9), 10'd29, 10'd29);
        single("full_max", pk(255, 255, 255, 255), 10'd1020, 10'd1020);
        single("full_mix", pk(15, 3, 200, 7), 10'd225, 10'd993);
        single("signed_min", pk(128, 128, 128, 128), 10'd512, 10'd512);
        single("signed_zero", pk(127, 255, 0, 130), 10'd512, 10'd0);

        // Streaming: eight back-to-back sets, results on eight consecutive cycles
        for (int i = 0; i < 10; i++) begin
            if (i < 8) begin
                in_data  = vec[i];
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
                in_data  = 32'h0;
            end
            tick();
            if (i >= 1 && i <= 8) begin
                chk($sformatf("stream%0d_valid", i-1), {31'd0, u_out_valid}, 32'd1);
                chk($sformatf("stream%0d_u_sum", i-1), {22'd0, u_out_sum}, {22'd0, exp_u[i-1]});
                chk($sformatf("stream%0d_s_sum", i-1), {22'd0, s_out_sum}, {22'd0, exp_s[i-1]});
            end
        end
        chk("stream_end_valid", {31'd0, u_out_valid}, 32'd0);

        // Backpressure: A at output, B in stage 0, C offered while stalled
        in_data  = pk(1, 2, 3, 4);
        in_valid = 1'b1;
        tick();
        in_data  = pk(100, 100, 100, 100);
        tick();
        chk("bp_a_valid", {31'd0, u_out_valid}, 32'd1);
        chk("bp_a_sum", {22'd0, u_out_sum}, 32'd10);
        out_ready = 1'b0;
        in_data   = pk(9, 9, 9, 9);
        #1;
        chk("bp_in_ready_low", {31'd0, u_in_ready}, 32'd0);
        for (int c = 0; c < 5; c++) begin
            in_data = pk(c, 9, 9, 9);
            tick();
            chk($sformatf("bp_stall%0d_valid", c), {31'd0, u_out_valid}, 32'd1);
            chk($sformatf("bp_stall%0d_sum", c), {22'd0, u_out_sum}, 32'd10);
            chk($sformatf("bp_stall%0d_in_ready", c), {31'd0, u_in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        in_data   = pk(128, 0, 0, 1);
        #1;
        chk("bp_in_ready_back", {31'd0, u_in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
        chk("bp_b_valid", {31'd0, u_out_valid}, 32'd1);
        chk("bp_b_sum", {22'd0, u_out_sum}, 32'd400);
        tick();
        chk("bp_c_valid", {31'd0, u_out_valid}, 32'd1);
        chk("bp_c_u_sum", {22'd0, u_out_sum}, 32'd129);
        chk("bp_c_s_sum", {22'd0, s_out_sum}, 32'd897);
        tick();
        chk("bp_drained", {31'd0, u_out_valid}, 32'd0);

        // Reset mid-flight with two sets in the pipe
        in_data  = pk(50, 50, 50, 50);
        in_valid = 1'b1;
        tick();
        in_data  = pk(60, 60, 60, 60);
        tick();
        in_valid = 1'b0;
        chk("mid_pre_valid", {31'd0, u_out_valid}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", {31'd0, u_out_valid}, 32'd0);
        chk("mid_rst_sum", {22'd0, u_out_sum}, 32'd0);
        chk("mid_rst_s_sum", {22'd0, s_out_sum}, 32'd0);
        chk("mid_rst_in_ready", {31'd0, u_in_ready}, 32'd1);
        tick();
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk($sformatf("mid_gone%0d", c), {31'd0, u_out_valid}, 32'd0);
        end
        single("post_rst", pk(1, 1, 1, 250), 10'd253, 10'd253 - 10'd256 + 10'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
